// File: rtl/smpl_iter_pkg.sv
// Shared types and helpers for the 4-lane sample iterator (smpl_iter4).
package smpl_iter_pkg;

  localparam int SIGFIG_C = 24;
  localparam int LANES_C  = 4;

  typedef logic signed [SIGFIG_C-1:0] sample_t;

  typedef enum logic {WAIT, TEST} state_t;

  // One-hot subSample: bit0..bit3 select ss_w_lg2 = 3,2,1,0.
  function automatic logic [31:0] ss_step(input logic [3:0] ss, input int radix);
    int lg2;
    lg2 = 0;
    if (ss[0])      lg2 = 3;
    else if (ss[1]) lg2 = 2;
    else if (ss[2]) lg2 = 1;
    return 32'd1 << (radix - lg2);
  endfunction

endpackage

// File: rtl/smpl_iter_lane_gen.sv
// Combinational lane generator: x position and validity for each lane of a group.
module smpl_iter_lane_gen #(
  parameter int SIGFIG = 24,
  parameter int LANES  = 4,
  parameter int W      = SIGFIG + 3
) (
  input  logic signed [W-1:0]             i_cur_x,
  input  logic signed [W-1:0]             i_cur_y,
  input  logic signed [W-1:0]             i_step,
  input  logic signed [W-1:0]             i_ur_x,
  input  logic signed [W-1:0]             i_ur_y,
  output logic        [LANES-1:0][SIGFIG-1:0] o_x,
  output logic        [LANES-1:0]         o_vld
);

  logic signed [W-1:0] w_x;

  always_comb begin
    w_x   = i_cur_x;
    o_x   = '0;
    o_vld = '0;
    for (int i = 0; i < LANES; i++) begin
      o_x[i]   = w_x[SIGFIG-1:0];
      o_vld[i] = (w_x <= i_ur_x) && (i_cur_y <= i_ur_y);
      w_x      = w_x + i_step;
    end
  end

endmodule

// File: rtl/smpl_iter4.sv
// 4-lane row-major sample iterator over a triangle's snapped bounding box.
// Optional macro SMPL_ITER_LAST_EN adds lastSamp_R14H end-of-triangle marker.
module smpl_iter4
  import smpl_iter_pkg::*;
#(
  parameter int SIGFIG = SIGFIG_C,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int LANES  = LANES_C
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]        color_R13U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]          box_R13S,
  input  logic                                        validTri_R13H,
  input  logic        [3:0]                           subSample_RnnnnU,
  input  logic                                        halt_ds_RnnnnL,
  output logic                                        halt_RnnnnL,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic        [COLORS-1:0][SIGFIG-1:0]        color_R14U,
  output logic signed [1:0][LANES-1:0][SIGFIG-1:0]    sample_R14S,
  output logic        [LANES-1:0]                     validSamp_R14H
`ifdef SMPL_ITER_LAST_EN
  , output logic                                      lastSamp_R14H
`endif
);

  localparam int W = SIGFIG + 3;

  function automatic logic signed [W-1:0] sext(input logic [SIGFIG-1:0] v);
    return {{(W-SIGFIG){v[SIGFIG-1]}}, v};
  endfunction

  state_t r_state, w_state_nxt;
  logic signed [W-1:0] r_cur_x, r_cur_y, r_ll_x, r_ur_x, r_ur_y, r_step;
  logic signed [W-1:0] w_in_llx, w_in_lly, w_in_urx, w_in_ury, w_in_step;
  logic signed [W-1:0] w_cur_x, w_cur_y, w_ll_x, w_ur_x, w_ur_y, w_step, w_stepn;
  logic signed [W-1:0] w_nxt_x, w_nxt_y;
  logic w_run, w_accept, w_active, w_done, w_drop;
  logic [LANES-1:0][SIGFIG-1:0] w_lane_x;
  logic [LANES-1:0]             w_lane_vld;

  assign w_run    = halt_ds_RnnnnL;
  assign w_accept = w_run && (r_state == WAIT) && validTri_R13H;
  assign w_active = w_accept || (w_run && (r_state == TEST));

  assign w_in_llx  = sext(box_R13S[0][0]);
  assign w_in_lly  = sext(box_R13S[0][1]);
  assign w_in_urx  = sext(box_R13S[1][0]);
  assign w_in_ury  = sext(box_R13S[1][1]);
  assign w_in_step = W'(ss_step(subSample_RnnnnU, RADIX));
  assign w_drop    = w_accept && ((w_in_urx < w_in_llx) || (w_in_ury < w_in_lly));

  // The accept cycle computes the first group straight from the incoming box.
  assign w_cur_x = w_accept ? w_in_llx  : r_cur_x;
  assign w_cur_y = w_accept ? w_in_lly  : r_cur_y;
  assign w_ll_x  = w_accept ? w_in_llx  : r_ll_x;
  assign w_ur_x  = w_accept ? w_in_urx  : r_ur_x;
  assign w_ur_y  = w_accept ? w_in_ury  : r_ur_y;
  assign w_step  = w_accept ? w_in_step : r_step;
  assign w_stepn = w_step <<< $clog2(LANES);

  smpl_iter_lane_gen #(.SIGFIG(SIGFIG), .LANES(LANES), .W(W)) u_lane_gen (
    .i_cur_x (w_cur_x),
    .i_cur_y (w_cur_y),
    .i_step  (w_step),
    .i_ur_x  (w_ur_x),
    .i_ur_y  (w_ur_y),
    .o_x     (w_lane_x),
    .o_vld   (w_lane_vld)
  );

  always_comb begin
    w_nxt_x = w_cur_x;
    w_nxt_y = w_cur_y;
    w_done  = 1'b0;
    if (w_cur_x + w_stepn <= w_ur_x) begin
      w_nxt_x = w_cur_x + w_stepn;
    end else if (w_cur_y + w_step <= w_ur_y) begin
      w_nxt_x = w_ll_x;
      w_nxt_y = w_cur_y + w_step;
    end else begin
      w_done = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT:    if (w_accept && !w_done && !w_drop) w_state_nxt = TEST;
      TEST:    if (w_run && w_done) w_state_nxt = WAIT;
      default: w_state_nxt = WAIT;
    endcase
  end

  always_comb begin
    halt_RnnnnL = w_run && (r_state == WAIT);
  end

  always_ff @(posedge clk) begin
    if (w_active) begin
      r_cur_x <= w_nxt_x;
      r_cur_y <= w_nxt_y;
    end
    if (w_accept) begin
      r_ll_x <= w_in_llx;
      r_ur_x <= w_in_urx;
      r_ur_y <= w_in_ury;
      r_step <= w_in_step;
    end
  end

  // R14 output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      tri_R14S       <= '0;
      color_R14U     <= '0;
      sample_R14S    <= '0;
      validSamp_R14H <= '0;
    end else if (w_run) begin
      if (w_accept) begin
        tri_R14S   <= tri_R13S;
        color_R14U <= color_R13U;
      end
      if (w_active) begin
        sample_R14S[0] <= w_lane_x;
        sample_R14S[1] <= {LANES{w_cur_y[SIGFIG-1:0]}};
        validSamp_R14H <= w_lane_vld & ~{LANES{w_drop}};
      end else begin
        validSamp_R14H <= '0;
      end
    end
  end

`ifdef SMPL_ITER_LAST_EN
  always_ff @(posedge clk) begin
    if (rst)        lastSamp_R14H <= 1'b0;
    else if (w_run) lastSamp_R14H <= w_active && (w_done || w_drop);
  end
`endif

endmodule

// File: tb/tb_smpl_iter4.sv
// Scoreboard bench for smpl_iter4; honours SMPL_ITER_LAST_EN when defined.
module tb_smpl_iter4;
  import smpl_iter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [2:0][2:0][23:0] tri_R13S = '0;
  logic        [2:0][23:0]      color_R13U = '0;
  logic signed [1:0][1:0][23:0] box_R13S = '0;
  logic                         validTri_R13H = 1'b0;
  logic        [3:0]            subSample_RnnnnU = 4'b1000;
  logic                         halt_ds_RnnnnL = 1'b1;
  logic                         halt_RnnnnL;
  logic signed [2:0][2:0][23:0] tri_R14S;
  logic        [2:0][23:0]      color_R14U;
  logic signed [1:0][3:0][23:0] sample_R14S;
  logic        [3:0]            validSamp_R14H;
  logic                         tb_last;
`ifdef SMPL_ITER_LAST_EN
  logic                         lastSamp_R14H;
  assign tb_last = lastSamp_R14H;
`else
  assign tb_last = 1'b0;
`endif

  smpl_iter4 dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_R13S),
    .color_R13U       (color_R13U),
    .box_R13S         (box_R13S),
    .validTri_R13H    (validTri_R13H),
    .subSample_RnnnnU (subSample_RnnnnU),
    .halt_ds_RnnnnL   (halt_ds_RnnnnL),
    .halt_RnnnnL      (halt_RnnnnL),
    .tri_R14S         (tri_R14S),
    .color_R14U       (color_R14U),
    .sample_R14S      (sample_R14S),
    .validSamp_R14H   (validSamp_R14H)
`ifdef SMPL_ITER_LAST_EN
    , .lastSamp_R14H  (lastSamp_R14H)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][23:0] x;
    sample_t          y;
    logic [3:0]       vld;
    logic             last;
    logic             chk_xy;
    logic [71:0]      col;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [23:0] x0, x1, x2, x3, y, input logic [3:0] vld,
                      input logic last, input logic chk_xy, input logic [71:0] col);
    exp_t e;
    e.x = {x3, x2, x1, x0};
    e.y = y;
    e.vld = vld;
    e.last = last;
    e.chk_xy = chk_xy;
    e.col = col;
    q.push_back(e);
  endtask

  // Present a triangle and hold it until the iterator accepts it.
  task automatic send_tri(input logic signed [23:0] llx, lly, urx, ury,
                          input logic [3:0] ss, input logic [71:0] col);
    int n;
    tri_R13S = {3{col}};
    color_R13U = col;
    box_R13S[0][0] = llx; box_R13S[0][1] = lly;
    box_R13S[1][0] = urx; box_R13S[1][1] = ury;
    subSample_RnnnnU = ss;
    validTri_R13H = 1'b1;
    n = 0;
    while (!halt_RnnnnL && n <= 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n > 50) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    validTri_R13H = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(nm, q.size(), 0);
  endtask

  // Consume a group whenever one is presented and downstream is not stalled.
  always @(negedge clk) begin
    if (halt_ds_RnnnnL && (validSamp_R14H != 4'b0 || tb_last)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_group: got valid %b with empty queue, expected no group", validSamp_R14H);
      end else begin
        mon_e = q.pop_front();
        chk("valid", validSamp_R14H, mon_e.vld);
        if (mon_e.chk_xy) begin
          chk("sample_x", sample_R14S[0], mon_e.x);
          chk("sample_y", sample_R14S[1], {4{mon_e.y}});
        end
        chk("color", color_R14U, mon_e.col);
        chk("tri", tri_R14S, {3{mon_e.col}});
`ifdef SMPL_ITER_LAST_EN
        chk("last", tb_last, mon_e.last);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    logic signed [1:0][3:0][23:0] snap_s;
    logic [3:0] snap_v;
    int c1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", validSamp_R14H, 0);
    chk("rst_halt", halt_RnnnnL, 1);
    chk("rst_sample", sample_R14S, 0);
    chk("rst_tri", tri_R14S, 0);
    chk("rst_color", color_R14U, 0);

    // T1: two rows of one full group each, step 1024
    push(0, 1024, 2048, 3072, 0,    4'b1111, 0, 1, 72'h000001_000002_000003);
    push(0, 1024, 2048, 3072, 1024, 4'b1111, 1, 1, 72'h000001_000002_000003);
    send_tri(0, 0, 3072, 1024, 4'b1000, 72'h000001_000002_000003);
    chk("t1_halt_iter", halt_RnnnnL, 0);
    @(posedge clk); #1;
    chk("t1_halt_last", halt_RnnnnL, 1);
    drain("t1_drain");

    // T2: partial second group at x=4096
    push(0,    1024, 2048, 3072, 0, 4'b1111, 0, 1, 72'h00000a_00000b_00000c);
    push(4096, 5120, 6144, 7168, 0, 4'b0001, 1, 1, 72'h00000a_00000b_00000c);
    send_tri(0, 0, 4096, 0, 4'b1000, 72'h00000a_00000b_00000c);
    drain("t2_drain");

    // T3: 3-cycle downstream stall after the first group
    push(0, 1024, 2048, 3072, 0,    4'b1111, 0, 1, 72'h000123_000456_000789);
    push(0, 1024, 2048, 3072, 1024, 4'b1111, 0, 1, 72'h000123_000456_000789);
    push(0, 1024, 2048, 3072, 2048, 4'b1111, 1, 1, 72'h000123_000456_000789);
    send_tri(0, 0, 3072, 2048, 4'b1000, 72'h000123_000456_000789);
    halt_ds_RnnnnL = 1'b0;
    snap_s = sample_R14S;
    snap_v = validSamp_R14H;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t3_stall_sample", sample_R14S, snap_s);
      chk("t3_stall_valid", validSamp_R14H, snap_v);
      chk("t3_stall_halt", halt_RnnnnL, 0);
    end
    halt_ds_RnnnnL = 1'b1;
    drain("t3_drain");

    // T4: back-to-back single-sample triangles
    push(0, 1024, 2048, 3072, 0, 4'b0001, 1, 1, 72'h0000ff_0000ee_0000dd);
    push(0, 1024, 2048, 3072, 0, 4'b0001, 1, 1, 72'h0000ff_0000ee_0000dd);
    send_tri(0, 0, 0, 0, 4'b1000, 72'h0000ff_0000ee_0000dd);
    c1 = acc_cyc;
    send_tri(0, 0, 0, 0, 4'b1000, 72'h0000ff_0000ee_0000dd);
    chk("t4_no_bubble", acc_cyc - c1, 1);
    drain("t4_drain");

    // T5: step 128, two rows
    push(1024, 1152, 1280, 1408, 1024, 4'b1111, 0, 1, 72'h000042_000043_000044);
    push(1024, 1152, 1280, 1408, 1152, 4'b1111, 1, 1, 72'h000042_000043_000044);
    send_tri(1024, 1024, 1408, 1152, 4'b0001, 72'h000042_000043_000044);
    drain("t5_drain");

    // T6: degenerate box dropped, next triangle accepted the following cycle
`ifdef SMPL_ITER_LAST_EN
    push(0, 0, 0, 0, 0, 4'b0000, 1, 0, 72'h000077_000088_000099);
`endif
    push(0, 1024, 2048, 3072, 0, 4'b0001, 1, 1, 72'h000005_000006_000007);
    send_tri(0, 0, -1024, 0, 4'b1000, 72'h000077_000088_000099);
    c1 = acc_cyc;
    chk("t6_degen_valid", validSamp_R14H, 0);
    send_tri(0, 0, 0, 0, 4'b1000, 72'h000005_000006_000007);
    chk("t6_next_accept", acc_cyc - c1, 1);
    drain("t6_drain");

    // Reset in the middle of a 4-row box
    push(0, 1024, 2048, 3072, 0, 4'b1111, 0, 1, 72'h000abc_000def_000123);
    send_tri(0, 0, 3072, 3072, 4'b1000, 72'h000abc_000def_000123);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", validSamp_R14H, 0);
    chk("rst_mid_halt", halt_RnnnnL, 1);
    chk("rst_mid_sample", sample_R14S, 0);
    repeat (5) @(posedge clk);
    drain("rst_mid_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
